regfile_access_ctrl: RTL and testbench
======================================

# regfile_access_ctrl

Sequencing controller that drives the register file's single-port interface (one write strobe, two read addresses, registered read data) on behalf of two clients: an operand-read requester (decode) and a writeback requester. It arbitrates the clients with valid/ready handshakes and guarantees reads and writes never share a register-file cycle. It returns both operands as one registered response. It sits between decode/writeback and the register file.

## Interface
- ADDR_W, 5, register-number width
- DATA_W, 4, register data width
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- rd_req_valid  in  1  operand-read request valid
- rd_req_ready  out  1  controller accepts read request
- rd_src1, rd_src2  in  ADDR_W  source register numbers
- rsp_valid  out  1  operand response valid
- rsp_ready  in  1  consumer accepts response
- rsp_data1, rsp_data2  out  DATA_W  operand values
- wb_valid  in  1  writeback request valid
- wb_ready  out  1  controller accepts writeback
- wb_addr  in  ADDR_W  destination register
- wb_data  in  DATA_W  writeback value
- rf_reg_write  out  1  register-file write strobe
- rf_read_register1, rf_read_register2  out  ADDR_W  register-file read addresses
- rf_write_register  out  ADDR_W  register-file write address
- rf_write_data  out  DATA_W  register-file write data
- rf_read_data1, rf_read_data2  in  DATA_W  register-file read data; updated on the clock edge that ends a cycle with rf_reg_write=0

## Operation
- States: IDLE, WR, RD, CAP, RSP.
- IDLE:
  - wb_ready=1 only if wb_valid and (not rd_req_valid or not last_wr).
  - rd_req_ready=1 only if rd_req_valid and wb_ready=0.
  - At most one request is accepted per cycle.
- Write accept: latch wb_addr/wb_data into rf_write_register/rf_write_data, set last_wr=1, go to WR.
- Read accept: latch rd_src1/rd_src2 into rf_read_register1/2, set last_wr=0, go to RD.
- WR: rf_reg_write=1 for exactly this one cycle, then go to IDLE.
- RD: rf_reg_write=0 and read addresses held stable; the register file samples at the end of RD. Go to CAP.
- CAP: rf_read_data1/2 are valid. Capture them into rsp_data1/2 at the end of CAP, then go to RSP.
- RSP: rsp_valid=1 and rsp_data held stable until rsp_ready=1. On rsp_valid & rsp_ready, go to IDLE.
- Fairness: when both clients are valid in IDLE, writeback wins unless the previous accepted op was a write (last_wr=1). Strict alternation under contention, so neither client starves.
- Ordering: a write accepted before a read completes before that read samples, so read-after-write returns the new value with no forwarding. The same register read twice in one request returns identical data.
- rf_read_register*, rf_write_register and rf_write_data hold their last latched values outside RD/WR. rf_reg_write=1 only in WR.
- rd_req_ready, wb_ready and rsp_valid are all 0 outside the states listed above.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, last_wr=0.
  - rf_reg_write=0; all rf_* addresses and data = 0.
  - rsp_valid=0, rsp_data1/2=0.
  - rd_req_ready and wb_ready evaluate combinationally from IDLE.
- Reset asserted during WR drops rf_reg_write at once. No write occurs unless a rising edge preceded the assertion.
- Reset asserted during RD, CAP or RSP discards the pending response.
- Write: accept edge E → rf_reg_write=1 in cycle E+1 → IDLE at E+2. Throughput is 1 write per 2 cycles.
- Read: accept edge E → RD in E+1, CAP in E+2, rsp_valid=1 from E+3. A request accepted at E completes at the earliest at E+4 when rsp_ready=1; the next accept is possible at E+4.
- Backpressure: rsp_ready=0 holds RSP indefinitely. rsp_data stays unchanged and no new requests are accepted.
- rd_req_ready and wb_ready are combinational from state, valids and last_wr. No combinational path exists from rsp_ready to any rf_* output.

## Test plan
- Reset, then wb_valid with addr=3, data=0xA → wb_ready=1 in the first cycle. rf_reg_write=1 exactly one cycle later with rf_write_register=3 and rf_write_data=0xA; strobe deasserted after.
- After that write, read request src1=3, src2=3 with rsp_ready=1 → rsp_valid at accept+3, rsp_data1=rsp_data2=0xA, then IDLE.
- wb_valid (addr=5, data=0x7) and rd_req_valid (src1=5) asserted together from reset → write accepted first. Read accepted at the next IDLE and returns 0x7. Repeated contention alternates W,R,W,R.
- rsp_ready held 0 for 10 cycles in RSP → rsp_valid stays 1, rsp_data stable, rd_req_ready=wb_ready=0 throughout. Release → completion in 1 cycle.
- reset_n pulled low mid-WR before the edge → rf_reg_write falls immediately. A subsequent read of that register returns the old value; all outputs are at reset values.

Source files
------------

// File: rtl/regfile_access_ctrl.sv
// Sequencer that arbitrates decode operand reads and writeback writes onto a
// single-port register file, keeping reads and writes in separate cycles.
module regfile_access_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rd_req_valid_i,
  output logic              rd_req_ready_o,
  input  logic [ADDR_W-1:0] rd_src1_i,
  input  logic [ADDR_W-1:0] rd_src2_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data1_o,
  output logic [DATA_W-1:0] rsp_data2_o,
  input  logic              wb_valid_i,
  output logic              wb_ready_o,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              rf_reg_write_o,
  output logic [ADDR_W-1:0] rf_read_register1_o,
  output logic [ADDR_W-1:0] rf_read_register2_o,
  output logic [ADDR_W-1:0] rf_write_register_o,
  output logic [DATA_W-1:0] rf_write_data_o,
  input  logic [DATA_W-1:0] rf_read_data1_i,
  input  logic [DATA_W-1:0] rf_read_data2_i
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR   = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_CAP  = 3'd3;
  localparam logic [2:0] S_RSP  = 3'd4;

  logic [2:0]              state_q, state_d;
  logic                    last_wr_q, last_wr_d;
  logic [ADDR_W-1:0]       wr_addr_q;
  logic [DATA_W-1:0]       wr_data_q;
  logic [1:0][ADDR_W-1:0]  rd_addr_q;
  logic [1:0][DATA_W-1:0]  rsp_data_q;
  logic [1:0][ADDR_W-1:0]  rd_src_w;
  logic [1:0][DATA_W-1:0]  rf_rdata_w;
  logic                    is_idle;
  logic                    wr_accept;
  logic                    rd_accept;
  logic                    capture;

  assign rd_src_w   = {rd_src2_i, rd_src1_i};
  assign rf_rdata_w = {rf_read_data2_i, rf_read_data1_i};

  // Writeback wins contention unless it won last time, giving strict alternation.
  assign is_idle        = (state_q == S_IDLE);
  assign wb_ready_o     = is_idle & wb_valid_i & (~rd_req_valid_i | ~last_wr_q);
  assign rd_req_ready_o = is_idle & rd_req_valid_i & ~wb_ready_o;
  assign wr_accept      = wb_ready_o;
  assign rd_accept      = rd_req_ready_o;
  assign capture        = (state_q == S_CAP);

  assign rf_reg_write_o      = (state_q == S_WR);
  assign rsp_valid_o         = (state_q == S_RSP);
  assign rf_write_register_o = wr_addr_q;
  assign rf_write_data_o     = wr_data_q;
  assign rf_read_register1_o = rd_addr_q[0];
  assign rf_read_register2_o = rd_addr_q[1];
  assign rsp_data1_o         = rsp_data_q[0];
  assign rsp_data2_o         = rsp_data_q[1];

  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    case (state_q)
      S_IDLE: begin
        if (wr_accept) begin
          state_d   = S_WR;
          last_wr_d = 1'b1;
        end else if (rd_accept) begin
          state_d   = S_RD;
          last_wr_d = 1'b0;
        end
      end
      S_WR:    state_d = S_IDLE;
      S_RD:    state_d = S_CAP;
      S_CAP:   state_d = S_RSP;
      S_RSP:   if (rsp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      last_wr_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      if (wr_accept) begin
        wr_addr_q <= wb_addr_i;
        wr_data_q <= wb_data_i;
      end
    end
  end

  // Two identical read lanes: address latched on accept, data captured in CAP.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rd_addr_q[gi]  <= '0;
        rsp_data_q[gi] <= '0;
      end else begin
        if (rd_accept) rd_addr_q[gi] <= rd_src_w[gi];
        if (capture)   rsp_data_q[gi] <= rf_rdata_w[gi];
      end
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: a simple register file model, a cycle-level
// transaction model compared every cycle, and directed literal expectations.
module tb_regfile_access_ctrl;
  localparam int AW = 5;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_req_valid = 1'b0;
  logic          rd_req_ready;
  logic [AW-1:0] rd_src1 = '0;
  logic [AW-1:0] rd_src2 = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data1, rsp_data2;
  logic          wb_valid = 1'b0;
  logic          wb_ready;
  logic [AW-1:0] wb_addr = '0;
  logic [DW-1:0] wb_data = '0;
  logic          rf_reg_write;
  logic [AW-1:0] rf_ra1, rf_ra2, rf_wa;
  logic [DW-1:0] rf_wd;
  logic [DW-1:0] rf_rd1 = '0;
  logic [DW-1:0] rf_rd2 = '0;
  logic [DW-1:0] rf_mem [32] = '{default: '0};

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_access_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .rd_req_valid_i      (rd_req_valid),
    .rd_req_ready_o      (rd_req_ready),
    .rd_src1_i           (rd_src1),
    .rd_src2_i           (rd_src2),
    .rsp_valid_o         (rsp_valid),
    .rsp_ready_i         (rsp_ready),
    .rsp_data1_o         (rsp_data1),
    .rsp_data2_o         (rsp_data2),
    .wb_valid_i          (wb_valid),
    .wb_ready_o          (wb_ready),
    .wb_addr_i           (wb_addr),
    .wb_data_i           (wb_data),
    .rf_reg_write_o      (rf_reg_write),
    .rf_read_register1_o (rf_ra1),
    .rf_read_register2_o (rf_ra2),
    .rf_write_register_o (rf_wa),
    .rf_write_data_o     (rf_wd),
    .rf_read_data1_i     (rf_rd1),
    .rf_read_data2_i     (rf_rd2)
  );

  // Single-port register file: writes when strobed, otherwise reads.
  always @(posedge clk) begin
    if (rf_reg_write) rf_mem[rf_wa] <= rf_wd;
    else begin
      rf_rd1 <= rf_mem[rf_ra1];
      rf_rd2 <= rf_mem[rf_ra2];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: timeline of when the controller is free, when the
  // write strobe fires and when a response appears, plus architectural state.
  initial begin
    int            cyc;
    int            free_at;
    int            rsp_at;
    int            wr_cycle;
    bit            pending;
    bit            m_last_wr;
    bit            idle, e_wb, e_rd, e_rsp;
    logic [DW-1:0] arch [32];
    logic [AW-1:0] m_wa, m_ra1, m_ra2;
    logic [DW-1:0] m_wd, m_rsp1, m_rsp2, pend1, pend2;
    cyc = 0; free_at = 0; rsp_at = 0; wr_cycle = -1; pending = 0; m_last_wr = 0;
    m_wa = '0; m_ra1 = '0; m_ra2 = '0; m_wd = '0; m_rsp1 = '0; m_rsp2 = '0;
    pend1 = '0; pend2 = '0;
    for (int i = 0; i < 32; i++) arch[i] = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        free_at = cyc; wr_cycle = -1; pending = 0; m_last_wr = 0;
        m_wa = '0; m_wd = '0; m_ra1 = '0; m_ra2 = '0; m_rsp1 = '0; m_rsp2 = '0;
      end
      if (pending && cyc == rsp_at) begin
        m_rsp1 = pend1;
        m_rsp2 = pend2;
      end
      idle  = !pending && (cyc >= free_at);
      e_wb  = idle && wb_valid && (!rd_req_valid || !m_last_wr);
      e_rd  = idle && rd_req_valid && !e_wb;
      e_rsp = pending && (cyc >= rsp_at);
      check("m_wb_ready",   wb_ready,     e_wb);
      check("m_rd_ready",   rd_req_ready, e_rd);
      check("m_reg_write",  rf_reg_write, (cyc == wr_cycle));
      check("m_wr_reg",     rf_wa,        m_wa);
      check("m_wr_data",    rf_wd,        m_wd);
      check("m_rd_reg1",    rf_ra1,       m_ra1);
      check("m_rd_reg2",    rf_ra2,       m_ra2);
      check("m_rsp_valid",  rsp_valid,    e_rsp);
      check("m_rsp_data1",  rsp_data1,    m_rsp1);
      check("m_rsp_data2",  rsp_data2,    m_rsp2);
      if (rst_n) begin
        if (cyc == wr_cycle) arch[m_wa] = m_wd;
        if (e_rsp && rsp_ready) begin
          pending = 0;
          free_at = cyc + 1;
        end
        if (e_wb) begin
          m_wa = wb_addr; m_wd = wb_data;
          wr_cycle = cyc + 1; free_at = cyc + 2; m_last_wr = 1;
        end else if (e_rd) begin
          m_ra1 = rd_src1; m_ra2 = rd_src2;
          pend1 = arch[rd_src1]; pend2 = arch[rd_src2];
          pending = 1; rsp_at = cyc + 3; m_last_wr = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  initial begin
    string order;
    look();
    check("rst_reg_write", rf_reg_write, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_wr_reg", rf_wa, 0);
    check("rst_rsp_data1", rsp_data1, 0);
    tick(); rst_n = 1'b1;

    // Write r3 = A, strobe exactly one cycle after accept.
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 4'hA;
    look(); check("t1_wb_ready", wb_ready, 1);
    tick(); wb_valid = 1'b0;
    look();
    check("t1_strobe", rf_reg_write, 1);
    check("t1_wr_reg", rf_wa, 3);
    check("t1_wr_data", rf_wd, 4'hA);
    tick(); look(); check("t1_strobe_off", rf_reg_write, 0);

    // Read r3,r3: response three cycles after accept.
    tick(); rd_req_valid = 1'b1; rd_src1 = 5'd3; rd_src2 = 5'd3; rsp_ready = 1'b1;
    look(); check("t2_rd_ready", rd_req_ready, 1);
    tick(); rd_req_valid = 1'b0;
    look(); check("t2_rd_cycle", rsp_valid, 0);
    tick(); look(); check("t2_cap_cycle", rsp_valid, 0);
    tick(); look();
    check("t2_rsp_valid", rsp_valid, 1);
    check("t2_rsp_data1", rsp_data1, 4'hA);
    check("t2_rsp_data2", rsp_data2, 4'hA);
    tick(); look(); check("t2_done", rsp_valid, 0);

    // Contention from reset: write first, then the read sees the new value.
    tick(); rst_n = 1'b0;
    look();
    tick(); rst_n = 1'b1;
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 4'h7;
    rd_req_valid = 1'b1; rd_src1 = 5'd5; rd_src2 = 5'd3;
    look(); check("t3_wb_first", wb_ready, 1); check("t3_rd_wait", rd_req_ready, 0);
    tick(); wb_valid = 1'b0;
    look(); check("t3_rd_in_wr", rd_req_ready, 0);
    tick(); look(); check("t3_rd_accept", rd_req_ready, 1);
    tick(); rd_req_valid = 1'b0;
    tick(); tick(); look();
    check("t3_rsp_valid", rsp_valid, 1);
    check("t3_rsp_data1", rsp_data1, 4'h7);
    check("t3_rsp_data2", rsp_data2, 4'hA);
    tick();

    // Sustained contention must alternate, starting with the write.
    wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 4'h2;
    rd_req_valid = 1'b1; rd_src1 = 5'd9; rd_src2 = 5'd5;
    order = "";
    for (int i = 0; i < 16 && order.len() < 4; i++) begin
      look();
      if (wb_ready) order = {order, "W"};
      else if (rd_req_ready) order = {order, "R"};
      tick();
    end
    checks++;
    if (order != "WRWR") begin
      failures++;
      $display("FAIL t3_alternation: got %s expected WRWR", order);
    end
    wb_valid = 1'b0; rd_req_valid = 1'b0;
    repeat (6) tick();

    // Backpressure: RSP holds with stable data and no accepts.
    rsp_ready = 1'b0; rd_req_valid = 1'b1; rd_src1 = 5'd5; rd_src2 = 5'd5;
    look(); check("t4_rd_ready", rd_req_ready, 1);
    tick(); wb_valid = 1'b1; wb_addr = 5'd1; wb_data = 4'hF; rd_src1 = 5'd1;
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      look();
      check("t4_hold_valid", rsp_valid, 1);
      check("t4_hold_data1", rsp_data1, 4'h7);
      check("t4_hold_data2", rsp_data2, 4'h7);
      check("t4_no_rd", rd_req_ready, 0);
      check("t4_no_wb", wb_ready, 0);
      tick();
    end
    rsp_ready = 1'b1; wb_valid = 1'b0; rd_req_valid = 1'b0;
    look(); check("t4_last_rsp", rsp_valid, 1);
    tick(); look(); check("t4_released", rsp_valid, 0);

    // Reset in the middle of a write cycle cancels the write.
    tick(); wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 4'hC;
    look(); check("t5_accept", wb_ready, 1);
    tick(); wb_valid = 1'b0;
    check("t5_strobe", rf_reg_write, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_strobe_drop", rf_reg_write, 0);
    check("t5_wr_reg_rst", rf_wa, 0);
    check("t5_wr_data_rst", rf_wd, 0);
    check("t5_rsp_data_rst", rsp_data1, 0);
    look();
    tick(); rst_n = 1'b1;
    rd_req_valid = 1'b1; rd_src1 = 5'd5; rd_src2 = 5'd5;
    look(); check("t5_rd_ready", rd_req_ready, 1);
    tick(); rd_req_valid = 1'b0;
    tick(); tick(); look();
    check("t5_rsp_valid", rsp_valid, 1);
    check("t5_old_value", rsp_data1, 4'h7);
    tick();

    // Randomized traffic with occasional asynchronous resets.
    for (int n = 0; n < 3000; n++) begin
      rst_n        = ($urandom_range(0, 199) != 0);
      wb_valid     = 1'($urandom_range(0, 1));
      wb_addr      = 5'($urandom_range(0, 7));
      wb_data      = 4'($urandom);
      rd_req_valid = 1'($urandom_range(0, 1));
      rd_src1      = 5'($urandom_range(0, 7));
      rd_src2      = 5'($urandom_range(0, 7));
      rsp_ready    = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst_n = 1'b1; wb_valid = 1'b0; rd_req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
